// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer codes and slave state encoding
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// rtl/ahb_lane_decode.sv - hsize/addr[1:0] to byte-lane strobe plus size/alignment error
module ahb_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strb,
  output logic       o_err
);

  always_comb begin
    o_strb = 4'b0000;
    o_err  = 1'b0;
    case (i_hsize)
      HSIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
      HSIZE_HALF: begin
        o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_err  = i_addr_lo[0];
      end
      HSIZE_WORD: begin
        o_strb = 4'b1111;
        o_err  = |i_addr_lo;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word-array memory slave with wait states and two-cycle ERROR
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  slave_state_t r_state;
  slave_state_t w_next;
  logic [2:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_strb;
  logic          r_write;
  logic [31:0]   r_mem [2**AW];

  logic [3:0] w_strb;
  logic       w_lane_err;
  logic       w_err;
  logic       w_take;
  logic       w_unused;

  ahb_lane_decode u_lane (
    .i_hsize   (hsize),
    .i_addr_lo (haddr[1:0]),
    .o_strb    (w_strb),
    .o_err     (w_lane_err)
  );

  assign w_err    = w_lane_err | (|haddr[31:AW+2]);
  // Gating with our own ready keeps WAIT/ERR1 deaf even if hready is mis-muxed.
  assign w_take   = hsel & htrans[1] & hready & hreadyout;
  assign w_unused = &{1'b0, hprot, htrans[0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_WAIT: w_next = (r_cnt == 3'd1) ? ST_DATA : ST_WAIT;
      ST_ERR1: w_next = ST_ERR2;
      default: begin
        if (w_take) w_next = w_err ? ST_ERR1 : ((WS != 3'd0) ? ST_WAIT : ST_DATA);
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = 32'h0;
    case (r_state)
      ST_WAIT: hreadyout = 1'b0;
      ST_DATA: if (!r_write) hrdata = r_mem[r_addr];
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_strb  <= 4'b0000;
      r_write <= 1'b0;
    end else begin
      if (r_state == ST_WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_take) begin
        r_addr  <= haddr[AW+1:2];
        r_strb  <= w_strb;
        r_write <= hwrite;
        r_cnt   <= WS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_DATA && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strb[i]) r_mem[r_addr][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench driving three slaves (0/2/3 wait states) on one bus
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hsel, hwrite, force_low;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  int          sel;

  logic        ro0, ro2, ro3, rs0, rs2, rs3;
  logic [31:0] rd0, rd2, rd3;
  logic        hsel0, hsel2, hsel3;
  logic        mux_ready, bus_resp, hready;
  logic [31:0] bus_rdata;

  assign hsel0 = hsel && (sel == 0);
  assign hsel2 = hsel && (sel == 2);
  assign hsel3 = hsel && (sel == 3);

  always_comb begin
    mux_ready = ro0;
    bus_resp  = rs0;
    bus_rdata = rd0;
    if (sel == 2) begin
      mux_ready = ro2; bus_resp = rs2; bus_rdata = rd2;
    end else if (sel == 3) begin
      mux_ready = ro3; bus_resp = rs3; bus_rdata = rd3;
    end
  end
  assign hready = force_low ? 1'b0 : mux_ready;

  ahb_sram_slave #(.AW(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

  ahb_sram_slave #(.AW(10), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

  ahb_sram_slave #(.AW(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro3), .hresp(rs3), .hrdata(rd3));

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        resp;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        resp;
    int          lat;
  } vec_t;

  exp_t pending[$];
  exp_t inflight;
  bit   dp_active = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Bus monitor: retire the completing data phase, then latch a newly accepted address phase.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active && hready) begin
        dp_active = 1'b0;
        check("resp", {31'd0, bus_resp}, {31'd0, inflight.resp});
        check("rdata", bus_rdata, (inflight.is_read && !inflight.resp) ? inflight.rdata : 32'h0);
        check("latency", 32'(cyc - inflight.acc), 32'(inflight.lat));
      end
      if (hsel && htrans[1] && hready) begin
        if (pending.size() == 0) begin
          timeout_fail("unexpected_accept");
        end else begin
          inflight     = pending.pop_front();
          inflight.acc = cyc;
          dp_active    = 1'b1;
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eresp,
                      input int elat);
    exp_t e;
    bit   ok;
    e.is_read = !w;
    e.rdata   = erd;
    e.resp    = eresp;
    e.lat     = elat;
    e.acc     = 0;
    pending.push_back(e);
    hsel   = 1'b1;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = w;
    hsize  = sz;
    ok     = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = hready;
    end
    if (!ok) timeout_fail("xfer_accept");
    @(posedge clk);
    #1;
    hwdata = wd;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      done = !dp_active && (pending.size() == 0);
    end
    if (!done) timeout_fail("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low;
    logic [31:0] err_addr [2];

    reset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 32'h0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hprot = 4'h3; hwdata = 32'h0; force_low = 1'b0; sel = 0;

    tbl[0]  = '{32'h20,   1'b1, HSIZE_WORD, 32'h11223344, 32'h0,        1'b0, 1};
    tbl[1]  = '{32'h20,   1'b0, HSIZE_WORD, 32'h0,        32'h11223344, 1'b0, 1};
    tbl[2]  = '{32'h21,   1'b1, HSIZE_BYTE, 32'h0000AA00, 32'h0,        1'b0, 1};
    tbl[3]  = '{32'h20,   1'b0, HSIZE_WORD, 32'h0,        32'h1122AA44, 1'b0, 1};
    tbl[4]  = '{32'h00,   1'b1, HSIZE_WORD, 32'hCAFEF00D, 32'h0,        1'b0, 1};
    tbl[5]  = '{32'h02,   1'b1, HSIZE_HALF, 32'h5A5A0000, 32'h0,        1'b0, 1};
    tbl[6]  = '{32'h00,   1'b0, HSIZE_WORD, 32'h0,        32'h5A5AF00D, 1'b0, 1};
    tbl[7]  = '{32'h22,   1'b0, HSIZE_HALF, 32'h0,        32'h1122AA44, 1'b0, 1};
    tbl[8]  = '{32'h03,   1'b1, HSIZE_BYTE, 32'h77000000, 32'h0,        1'b0, 1};
    tbl[9]  = '{32'h00,   1'b0, HSIZE_BYTE, 32'h0,        32'h775AF00D, 1'b0, 1};
    tbl[10] = '{32'h03,   1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0,        1'b1, 2};
    tbl[11] = '{32'h1000, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0,        1'b1, 2};
    tbl[12] = '{32'h01,   1'b1, HSIZE_HALF, 32'hFFFFFFFF, 32'h0,        1'b1, 2};
    tbl[13] = '{32'h04,   1'b1, 3'd3,       32'hFFFFFFFF, 32'h0,        1'b1, 2};
    tbl[14] = '{32'h00,   1'b0, HSIZE_WORD, 32'h0,        32'h775AF00D, 1'b0, 1};
    tbl[15] = '{32'h20,   1'b0, HSIZE_WORD, 32'h0,        32'h1122AA44, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready0", {31'd0, ro0}, 32'd1);
    check("reset_ready2", {31'd0, ro2}, 32'd1);
    check("reset_ready3", {31'd0, ro3}, 32'd1);
    check("reset_resp", {29'd0, rs0, rs2, rs3}, 32'd0);
    check("reset_rdata0", rd0, 32'h0);
    check("reset_rdata3", rd3, 32'h0);

    // Pipelined table on the zero-wait slave: each address phase overlaps the previous data phase.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      xfer(tbl[i].addr, tbl[i].w, tbl[i].sz, tbl[i].wd, tbl[i].rd, tbl[i].resp, tbl[i].lat);
    drain();

    err_addr[0] = 32'h03;
    err_addr[1] = 32'h1000;
    for (int k = 0; k < 2; k++) begin
      xfer(err_addr[k], 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b1, 2);
      @(negedge clk);
      check("err1_ready", {31'd0, hready}, 32'd0);
      check("err1_resp", {31'd0, bus_resp}, 32'd1);
      @(negedge clk);
      check("err2_ready", {31'd0, hready}, 32'd1);
      check("err2_resp", {31'd0, bus_resp}, 32'd1);
      drain();
    end
    xfer(32'h00, 1'b0, HSIZE_WORD, 32'h0, 32'h775AF00D, 1'b0, 1);
    drain();

    // IDLE with hsel high, then NONSEQ while another slave holds hready low.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_IDLE; hwrite = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD;
    hwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ro0}, 32'd1);
      check("idle_resp", {31'd0, rs0}, 32'd0);
    end
    @(posedge clk); #1;
    force_low = 1'b1; htrans = HTRANS_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", {31'd0, ro0}, 32'd1);
      check("stall_resp", {31'd0, rs0}, 32'd0);
    end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; force_low = 1'b0;
    xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, 32'h1122AA44, 1'b0, 1);
    drain();

    // Two wait states: halfword write to the upper lanes.
    sel = 2;
    xfer(32'h40, 1'b1, HSIZE_WORD, 32'h12345678, 32'h0, 1'b0, 3);
    drain();
    xfer(32'h42, 1'b1, HSIZE_HALF, 32'hBEEF0000, 32'h0, 1'b0, 3);
    n_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hready) break;
      n_low++;
    end
    check("ws2_low_cycles", 32'(n_low), 32'd2);
    check("ws2_done_resp", {31'd0, bus_resp}, 32'd0);
    drain();
    xfer(32'h40, 1'b0, HSIZE_WORD, 32'h0, 32'hBEEF5678, 1'b0, 3);
    drain();

    // Three wait states: reset lands mid-WAIT with a write pending.
    sel = 3;
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'h01020304, 32'h0, 1'b0, 4);
    drain();
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 1'b0, 4);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, ro3}, 32'd1);
    check("rst_mid_resp", {31'd0, rs3}, 32'd0);
    check("rst_mid_rdata", rd3, 32'h0);
    @(negedge clk);
    check("rst_mid_stays_ready", {31'd0, ro3}, 32'd1);
    @(posedge clk); #1;
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h01020304, 1'b0, 4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
